// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: FSM encoding, BCD limit
// and the prescaler width helper.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } stateT;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Bits needed to hold 0..clkPerTick-1 (never less than one bit).
  function automatic int preWidth(input int clkPerTick);
    return (clkPerTick < 2) ? 1 : $clog2(clkPerTick);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a rising-edge detector
// that yields a single-cycle pulse per press.
module btn_sync_edge (
  input  logic Clk,
  input  logic nReset,
  input  logic btnRaw,
  output logic btnPulse
);

  logic sync1;
  logic sync2;
  logic prevLvl;

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prevLvl <= 1'b0;
    end else begin
      sync1   <= btnRaw;
      sync2   <= sync1;
      prevLvl <= sync2;
    end
  end

  assign btnPulse = sync2 & ~prevLvl;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap sequencer for a 3-digit BCD stopwatch: debounced-edge buttons,
// 0.1 s prescaler, cascaded digit enables, counter clear and display hold.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_PER_TICK = 5000000,
  parameter bit WRAP         = 1'b1
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       StartStop,
  input  logic       Lap,
  input  logic       Clear,
  input  logic [3:0] Dig0,
  input  logic [3:0] Dig1,
  input  logic [3:0] Dig2,
  output logic       EnDec,
  output logic       EnOnes,
  output logic       EnTens,
  output logic       ClrCnt,
  output logic       DispHold,
  output logic       Running,
  output logic       Ovf
);

  localparam int            PW       = preWidth(CLK_PER_TICK);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_TICK - 1);

  logic ssPulse, lapPulse, clrPulse;

  btn_sync_edge uSyncStart (.Clk(Clk), .nReset(nReset), .btnRaw(StartStop), .btnPulse(ssPulse));
  btn_sync_edge uSyncLap   (.Clk(Clk), .nReset(nReset), .btnRaw(Lap),       .btnPulse(lapPulse));
  btn_sync_edge uSyncClear (.Clk(Clk), .nReset(nReset), .btnRaw(Clear),     .btnPulse(clrPulse));

  stateT         stateReg, stateNext;
  logic [PW-1:0] preReg, preNext;
  logic          enDecReg, enDecNext;
  logic          enOnesReg, enOnesNext;
  logic          enTensReg, enTensNext;
  logic          clrCntReg, clrCntNext;
  logic          ovfReg, ovfNext;
  logic          dispHoldReg, runningReg;

  // StartStop outranks Lap, which outranks Clear.
  logic ssEv, lapEv, clrEv;
  assign ssEv  = ssPulse;
  assign lapEv = lapPulse & ~ssPulse;
  assign clrEv = clrPulse & ~ssPulse & ~lapPulse;

  logic active, tc, d0Max, d1Max, d2Max, overflow;
  assign active   = (stateReg == RUN) || (stateReg == LAP);
  assign tc       = active && (preReg == PRE_LAST);
  assign d0Max    = (Dig0 == BCD_MAX);
  assign d1Max    = (Dig1 == BCD_MAX);
  assign d2Max    = (Dig2 == BCD_MAX);
  assign overflow = tc & d0Max & d1Max & d2Max;

  always_comb begin
    stateNext  = stateReg;
    preNext    = preReg;
    enDecNext  = 1'b0;
    enOnesNext = 1'b0;
    enTensNext = 1'b0;
    clrCntNext = 1'b0;
    ovfNext    = ovfReg;
    case (stateReg)
      IDLE: begin
        if (ssEv) begin
          stateNext = RUN;
          preNext   = '0;
        end else if (clrEv) begin
          clrCntNext = 1'b1;
        end
      end
      RUN, LAP: begin
        // A stop on the TC cycle freezes the prescaler at its last count.
        if (ssEv) begin
          stateNext = STOP;
        end else if (overflow && !WRAP) begin
          stateNext = STOP;
          ovfNext   = 1'b1;
          preNext   = '0;
        end else begin
          preNext    = tc ? '0 : preReg + 1'b1;
          enDecNext  = tc;
          enOnesNext = tc & d0Max;
          enTensNext = tc & d0Max & d1Max;
          if (lapEv) stateNext = (stateReg == RUN) ? LAP : RUN;
        end
      end
      STOP: begin
        if (ssEv) begin
          if (!ovfReg) stateNext = RUN;
        end else if (clrEv) begin
          stateNext  = IDLE;
          clrCntNext = 1'b1;
          ovfNext    = 1'b0;
          preNext    = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      stateReg    <= IDLE;
      preReg      <= '0;
      enDecReg    <= 1'b0;
      enOnesReg   <= 1'b0;
      enTensReg   <= 1'b0;
      clrCntReg   <= 1'b0;
      ovfReg      <= 1'b0;
      dispHoldReg <= 1'b0;
      runningReg  <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      preReg      <= preNext;
      enDecReg    <= enDecNext;
      enOnesReg   <= enOnesNext;
      enTensReg   <= enTensNext;
      clrCntReg   <= clrCntNext;
      ovfReg      <= ovfNext;
      dispHoldReg <= (stateNext == LAP);
      runningReg  <= (stateNext == RUN) || (stateNext == LAP);
    end
  end

  assign EnDec    = enDecReg;
  assign EnOnes   = enOnesReg;
  assign EnTens   = enTensReg;
  assign ClrCnt   = clrCntReg;
  assign DispHold = dispHoldReg;
  assign Running  = runningReg;
  assign Ovf      = ovfReg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: one wrapping and one halting instance share the
// buttons; each drives its own modelled BCD counter and is checked every cycle.
module tb_stopwatch_ctrl;

  localparam int CPT     = 4;
  localparam int MAXSTEP = 10000;

  logic Clk = 1'b1;
  logic nReset = 1'b0;
  logic StartStop = 1'b0, Lap = 1'b0, Clear = 1'b0;
  logic [3:0] dig0 [2];
  logic [3:0] dig1 [2];
  logic [3:0] dig2 [2];
  logic [1:0] enDec, enOnes, enTens, clrCnt, dispHold, running, ovf;

  always #5 Clk = ~Clk;

  stopwatch_ctrl #(.CLK_PER_TICK(CPT), .WRAP(1'b1)) dutWrap (
    .Clk(Clk), .nReset(nReset), .StartStop(StartStop), .Lap(Lap), .Clear(Clear),
    .Dig0(dig0[0]), .Dig1(dig1[0]), .Dig2(dig2[0]),
    .EnDec(enDec[0]), .EnOnes(enOnes[0]), .EnTens(enTens[0]), .ClrCnt(clrCnt[0]),
    .DispHold(dispHold[0]), .Running(running[0]), .Ovf(ovf[0]));

  stopwatch_ctrl #(.CLK_PER_TICK(CPT), .WRAP(1'b0)) dutHalt (
    .Clk(Clk), .nReset(nReset), .StartStop(StartStop), .Lap(Lap), .Clear(Clear),
    .Dig0(dig0[1]), .Dig1(dig1[1]), .Dig2(dig2[1]),
    .EnDec(enDec[1]), .EnOnes(enOnes[1]), .EnTens(enTens[1]), .ClrCnt(clrCnt[1]),
    .DispHold(dispHold[1]), .Running(running[1]), .Ovf(ovf[1]));

  // Reference model: mode 0=idle 1=run 2=lap 3=stop; phase = cycles into the tenth.
  int mode [2];
  int phase [2];
  bit mOvf [2];
  int cnt [2];
  bit eEnDec [2], eEnOnes [2], eEnTens [2], eClr [2], eHold [2], eRun [2], eOvf [2];
  bit lvlSS [MAXSTEP];
  bit lvlLap [MAXSTEP];
  bit lvlClr [MAXSTEP];
  int stepNo = 0;
  int resetStep = 0;
  int tests = 0;
  int failures = 0;

  function automatic bit lvAt(input int which, input int k);
    if (k < 0 || k < resetStep) return 1'b0;
    case (which)
      0:       return lvlSS[k];
      1:       return lvlLap[k];
      default: return lvlClr[k];
    endcase
  endfunction

  // A level set at step k is acted on at the falling edge two steps later.
  function automatic bit pressed(input int which, input int e);
    return lvAt(which, e - 2) && !lvAt(which, e - 3);
  endfunction

  task automatic check(input string tag, input int i, input logic obs, input bit exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%b expected=%b step=%0d", tag, i, obs, exp, stepNo);
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      bit ss, lp, cl, tc;
      eEnDec[i] = 0; eEnOnes[i] = 0; eEnTens[i] = 0; eClr[i] = 0;
      if (!nReset) begin
        mode[i] = 0; phase[i] = 0; mOvf[i] = 0; cnt[i] = 0;
      end else begin
        ss = pressed(0, stepNo);
        lp = pressed(1, stepNo) && !ss;
        cl = pressed(2, stepNo) && !ss && !lp;
        tc = (mode[i] == 1 || mode[i] == 2) && phase[i] == CPT - 1;
        if (mode[i] == 0) begin
          if (ss) begin mode[i] = 1; phase[i] = 0; end
          else if (cl) eClr[i] = 1;
        end else if (mode[i] == 3) begin
          if (ss) begin
            if (!mOvf[i]) mode[i] = 1;
          end else if (cl) begin
            mode[i] = 0; eClr[i] = 1; mOvf[i] = 0; phase[i] = 0;
          end
        end else begin
          if (ss) mode[i] = 3;
          else if (tc && cnt[i] == 999 && i == 1) begin
            mode[i] = 3; mOvf[i] = 1; phase[i] = 0;
          end else begin
            phase[i] = (phase[i] + 1) % CPT;
            if (tc) begin
              eEnDec[i]  = 1;
              eEnOnes[i] = (cnt[i] % 10) == 9;
              eEnTens[i] = (cnt[i] % 100) == 99;
            end
            if (lp) mode[i] = (mode[i] == 1) ? 2 : 1;
          end
        end
      end
      eRun[i]  = (mode[i] == 1 || mode[i] == 2);
      eHold[i] = (mode[i] == 2);
      eOvf[i]  = mOvf[i];
    end
    if (!nReset) resetStep = stepNo + 1;
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) begin
      dig0[i] = 4'(cnt[i] % 10);
      dig1[i] = 4'((cnt[i] / 10) % 10);
      dig2[i] = 4'(cnt[i] / 100);
    end
    lvlSS[stepNo] = StartStop;
    lvlLap[stepNo] = Lap;
    lvlClr[stepNo] = Clear;
    modelEdge();
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      check("EnDec", i, enDec[i], eEnDec[i]);
      check("EnOnes", i, enOnes[i], eEnOnes[i]);
      check("EnTens", i, enTens[i], eEnTens[i]);
      check("ClrCnt", i, clrCnt[i], eClr[i]);
      check("DispHold", i, dispHold[i], eHold[i]);
      check("Running", i, running[i], eRun[i]);
      check("Ovf", i, ovf[i], eOvf[i]);
      if (eClr[i]) cnt[i] = 0;
      else if (eEnDec[i]) cnt[i] = (cnt[i] + 1) % 1000;
    end
    stepNo++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input bit s, input bit l, input bit c, input int hold);
    StartStop = s; Lap = l; Clear = c;
    repeat (hold) step();
    StartStop = 0; Lap = 0; Clear = 0;
    step();
  endtask

  initial begin
    int hS, hL, hC;
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 2; i++) begin mode[i] = 0; phase[i] = 0; mOvf[i] = 0; end

    run(3);                       // held in reset
    nReset = 1'b1;
    run(2);
    press(1, 0, 0, 2); run(20);   // start, tenths only
    cnt[0] = 399; cnt[1] = 399; run(8);
    cnt[0] = 997; cnt[1] = 997; run(16);  // wrap vs halt at 99.9
    press(1, 0, 0, 1); run(6);    // halted instance ignores StartStop
    press(0, 0, 1, 1); run(6);    // clear back to idle
    press(1, 0, 0, 1); run(6);
    press(0, 1, 0, 1); run(10);   // lap
    press(0, 1, 0, 1); run(6);    // unlap
    press(0, 1, 0, 1); run(3);
    press(1, 0, 0, 1); run(5);    // stop from lap
    press(1, 0, 0, 1); run(7);
    press(1, 0, 0, 1); run(20);   // partial tenth held while stopped
    press(1, 0, 0, 1); run(8);
    press(1, 0, 0, 1); run(5);
    press(1, 0, 1, 1); run(6);    // StartStop beats Clear in STOP

    #2 nReset = 1'b0;             // asynchronous reset between edges
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rstEnDec", i, enDec[i], 1'b0);
      check("rstClrCnt", i, clrCnt[i], 1'b0);
      check("rstDispHold", i, dispHold[i], 1'b0);
      check("rstRunning", i, running[i], 1'b0);
      check("rstOvf", i, ovf[i], 1'b0);
    end
    run(2);
    nReset = 1'b1;
    run(5);
    StartStop = 1'b1; run(14);    // held level starts once only
    StartStop = 1'b0; run(4);

    hS = 0; hL = 0; hC = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hS > 0) hS--; else if ($urandom_range(0, 24) == 0) hS = $urandom_range(1, 3);
      if (hL > 0) hL--; else if ($urandom_range(0, 29) == 0) hL = $urandom_range(1, 3);
      if (hC > 0) hC--; else if ($urandom_range(0, 59) == 0) hC = $urandom_range(1, 3);
      StartStop = (hS > 0); Lap = (hL > 0); Clear = (hC > 0);
      if ($urandom_range(0, 299) == 0) begin
        int v;
        v = $urandom_range(985, 999);
        cnt[0] = v; cnt[1] = v;
      end
      step();
    end
    StartStop = 0; Lap = 0; Clear = 0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
